// File: rtl/vector_register_bank_if.sv
// rtl/vector_register_bank_if.sv - register bank access bus: clear, write port, two read ports, status
interface vector_register_bank_if #(
  parameter int LANE_BITS = 32,
  parameter int LANES     = 4,
  parameter int NREGS     = 16
);
  localparam int AW = $clog2(NREGS);
  localparam int VW = LANES * LANE_BITS;

  logic             clr;
  logic             we3;
  logic [LANES-1:0] wm3;
  logic [AW-1:0]    a1;
  logic [AW-1:0]    a2;
  logic [AW-1:0]    a3;
  logic [VW-1:0]    wd3;
  logic [VW-1:0]    rd1;
  logic [VW-1:0]    rd2;
  logic             busy;
  logic             drop;

  modport master (
    output clr, we3, wm3, a1, a2, a3, wd3,
    input  rd1, rd2, busy, drop
  );

  modport slave (
    input  clr, we3, wm3, a1, a2, a3, wd3,
    output rd1, rd2, busy, drop
  );
endinterface

// File: rtl/vector_register_bank.sv
// rtl/vector_register_bank.sv - multi-lane vector register file with masked writes and init sweep
// Optional same-cycle write-to-read forwarding: define VRF_BYPASS_EN.
module vector_register_bank #(
  parameter int LANE_BITS = 32,
  parameter int LANES     = 4,
  parameter int NREGS     = 16,
  parameter int R0_INIT   = 65536,
  parameter int R1_INIT   = 81928
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  vector_register_bank_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int VW = LANES * LANE_BITS;
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic          busy_q;
  logic          drop_q;
  logic [VW-1:0] regs_q [NREGS];

  logic          wr_req;
  logic          wr_ok;
  logic [AW-1:0] sweep_idx;
  logic [VW-1:0] rd1_d;
  logic [VW-1:0] rd2_d;

  function automatic logic [VW-1:0] init_val(input logic [AW-1:0] idx);
    logic [LANE_BITS-1:0] v;
    v = '0;
    if (idx == '0)
      v = LANE_BITS'(R0_INIT);
    else if (idx == AW'(1))
      v = LANE_BITS'(R1_INIT);
    return {LANES{v}};
  endfunction

  assign wr_req = bus.we3 && (bus.wm3 != '0);
  assign wr_ok  = (state_q == READY) && !bus.clr && bus.we3;

  // A CLR seen during the sweep restarts it on the same edge by rewriting register 0.
  always_comb begin
    sweep_idx = cnt_q[AW-1:0];
    if (bus.clr)
      sweep_idx = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= wr_req && (busy_q || bus.clr);
      case (state_q)
        INIT: begin
          if (bus.clr) begin
            cnt_q <= (AW+1)'(1);
          end else if (cnt_q == LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (bus.clr) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // The array itself carries no reset; the sweep is what gives it defined contents.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      regs_q[sweep_idx] <= init_val(sweep_idx);
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wm3[i])
          regs_q[bus.a3][i*LANE_BITS +: LANE_BITS] <= bus.wd3[i*LANE_BITS +: LANE_BITS];
      end
    end
  end

  always_comb begin
    rd1_d = regs_q[bus.a1];
    rd2_d = regs_q[bus.a2];
`ifdef VRF_BYPASS_EN
    if (bus.we3 && !busy_q && !bus.clr) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wm3[i] && (bus.a3 == bus.a1))
          rd1_d[i*LANE_BITS +: LANE_BITS] = bus.wd3[i*LANE_BITS +: LANE_BITS];
        if (bus.wm3[i] && (bus.a3 == bus.a2))
          rd2_d[i*LANE_BITS +: LANE_BITS] = bus.wd3[i*LANE_BITS +: LANE_BITS];
      end
    end
`endif
    if (busy_q) begin
      rd1_d = '0;
      rd2_d = '0;
    end
  end

  assign bus.rd1  = rd1_d;
  assign bus.rd2  = rd2_d;
  assign bus.busy = busy_q;
  assign bus.drop = drop_q;
endmodule

// File: tb/tb_vector_register_bank.sv
// tb/tb_vector_register_bank.sv - self-checking bench for vector_register_bank
module tb_vector_register_bank;
  localparam int VW = 128;

  typedef struct {
    logic          we;
    logic [3:0]    wm;
    logic [3:0]    a3;
    logic [VW-1:0] wd;
    logic [3:0]    a1;
    logic [3:0]    a2;
    logic [VW-1:0] e1;
    logic [VW-1:0] e2;
    logic          edrop;
  } vec_t;

  typedef struct {
    logic [VW-1:0] e1;
    logic [VW-1:0] e2;
    logic          edrop;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sbq[$];

  vector_register_bank_if #(.LANE_BITS(32), .LANES(4), .NREGS(16)) vif ();

  vector_register_bank #(
    .LANE_BITS(32), .LANES(4), .NREGS(16), .R0_INIT(65536), .R1_INIT(81928)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] l4(input logic [31:0] l3, input logic [31:0] l2,
                                       input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] rep(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vif.clr = 1'b0;
    vif.we3 = 1'b0;
    vif.wm3 = 4'h0;
    vif.a3  = 4'd0;
    vif.wd3 = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      edge_step();
      n++;
    end while (vif.busy && n < 200);
  endtask

  task automatic read_chk(input string name, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [VW-1:0] e1, input logic [VW-1:0] e2);
    vif.a1 = a1;
    vif.a2 = a2;
    #1;
    chk({name, "_rd1"}, vif.rd1, e1);
    chk({name, "_rd2"}, vif.rd2, e2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[7];
    exp_t          ex;
    exp_t          got;
    int            n;
    logic [VW-1:0] I0;
    logic [VW-1:0] I1;
    logic [VW-1:0] R3;

    n_cmp = 0;
    n_err = 0;
    I0 = rep(32'h0001_0000);
    I1 = rep(32'h0001_4008);
    R3 = l4(32'h4, 32'hC, 32'h2, 32'hA);

    tbl[0] = '{1'b1, 4'b0101, 4'd3,  l4(32'hD, 32'hC, 32'hB, 32'hA), 4'd3,  4'd3,
               l4(32'h0, 32'hC, 32'h0, 32'hA), l4(32'h0, 32'hC, 32'h0, 32'hA), 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 4'd3,  {VW{1'b1}}, 4'd3, 4'd0,
               l4(32'h0, 32'hC, 32'h0, 32'hA), I0, 1'b0};
    tbl[2] = '{1'b1, 4'b1010, 4'd3,  l4(32'h4, 32'h3, 32'h2, 32'h1), 4'd3, 4'd1, R3, I1, 1'b0};
    tbl[3] = '{1'b0, 4'b1111, 4'd3,  {VW{1'b1}}, 4'd3, 4'd5, R3, '0, 1'b0};
    tbl[4] = '{1'b1, 4'b1111, 4'd15, l4(32'h11, 32'h22, 32'h33, 32'h44), 4'd15, 4'd3,
               l4(32'h11, 32'h22, 32'h33, 32'h44), R3, 1'b0};
    tbl[5] = '{1'b1, 4'b1000, 4'd0,  rep(32'h99), 4'd0, 4'd15,
               l4(32'h99, 32'h1_0000, 32'h1_0000, 32'h1_0000), l4(32'h11, 32'h22, 32'h33, 32'h44), 1'b0};
    tbl[6] = '{1'b0, 4'b0000, 4'd0,  '0, 4'd1, 4'd5, I1, '0, 1'b0};

    // reset state and first sweep
    idle();
    vif.a1 = 4'd0;
    vif.a2 = 4'd1;
    rst_n = 1'b0;
    #12;
    chk("reset_busy", VW'(vif.busy), VW'(1));
    chk("reset_drop", VW'(vif.drop), VW'(0));
    chk("reset_rd1_forced0", vif.rd1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_len_after_reset", VW'(n), VW'(16));
    read_chk("init_r0_r1", 4'd0, 4'd1, I0, I1);
    read_chk("init_r5_r15", 4'd5, 4'd15, '0, '0);

    // table-driven masked writes through the scoreboard
    for (int i = 0; i < 7; i++) begin
      vif.we3 = tbl[i].we;
      vif.wm3 = tbl[i].wm;
      vif.a3  = tbl[i].a3;
      vif.wd3 = tbl[i].wd;
      vif.a1  = tbl[i].a1;
      vif.a2  = tbl[i].a2;
      ex.e1 = tbl[i].e1;
      ex.e2 = tbl[i].e2;
      ex.edrop = tbl[i].edrop;
      sbq.push_back(ex);
      edge_step();
      got = sbq.pop_front();
      chk($sformatf("tbl%0d_rd1", i), vif.rd1, got.e1);
      chk($sformatf("tbl%0d_rd2", i), vif.rd2, got.e2);
      chk($sformatf("tbl%0d_drop", i), VW'(vif.drop), VW'(got.edrop));
    end
    idle();

    // write on cycle 4 of a sweep is dropped
    rst_n = 1'b0;
    edge_step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) edge_step();
    vif.we3 = 1'b1;
    vif.wm3 = 4'hF;
    vif.a3  = 4'd7;
    vif.wd3 = {VW{1'b1}};
    edge_step();
    idle();
    chk("sweep_write_drop_pulse", VW'(vif.drop), VW'(1));
    edge_step();
    chk("sweep_write_drop_clears", VW'(vif.drop), VW'(0));
    wait_ready(n);
    chk("sweep_len_remaining", VW'(n), VW'(11));
    read_chk("r7_r15_after_sweep", 4'd7, 4'd15, '0, '0);

    // CLR with a simultaneous write, then CLR again mid-sweep
    vif.we3 = 1'b1;
    vif.wm3 = 4'hF;
    vif.a3  = 4'd0;
    vif.wd3 = rep(32'h1);
    edge_step();
    read_chk("r0_overwritten", 4'd0, 4'd1, rep(32'h1), I1);
    vif.a3  = 4'd4;
    vif.wd3 = rep(32'h77);
    vif.clr = 1'b1;
    edge_step();
    idle();
    chk("clr_write_drop", VW'(vif.drop), VW'(1));
    chk("clr_busy_rises", VW'(vif.busy), VW'(1));
    wait_ready(n);
    chk("clr_sweep_len", VW'(n), VW'(16));
    read_chk("clr_restores_r0_r1", 4'd0, 4'd1, I0, I1);
    read_chk("clr_clears_r4_r3", 4'd4, 4'd3, '0, '0);
    vif.clr = 1'b1;
    edge_step();
    vif.clr = 1'b0;
    for (int i = 0; i < 5; i++) edge_step();
    vif.clr = 1'b1;
    edge_step();
    vif.clr = 1'b0;
    wait_ready(n);
    chk("clr_restart_len", VW'(n), VW'(15));

    // reset pulse mid-sweep
    vif.clr = 1'b1;
    edge_step();
    vif.clr = 1'b0;
    for (int i = 0; i < 8; i++) edge_step();
    rst_n = 1'b0;
    #1;
    chk("midsweep_reset_busy", VW'(vif.busy), VW'(1));
    edge_step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("midsweep_reset_len", VW'(n), VW'(16));
    read_chk("midsweep_reset_r1", 4'd1, 4'd0, I1, I0);

    // same-cycle read/write of one address
    vif.a1  = 4'd2;
    vif.a2  = 4'd2;
    vif.a3  = 4'd2;
    vif.we3 = 1'b1;
    vif.wm3 = 4'b0011;
    vif.wd3 = rep(32'h5);
    #1;
`ifdef VRF_BYPASS_EN
    chk("same_cycle_rd1", vif.rd1, l4(32'h0, 32'h0, 32'h5, 32'h5));
    chk("same_cycle_rd2", vif.rd2, l4(32'h0, 32'h0, 32'h5, 32'h5));
`else
    chk("same_cycle_rd1", vif.rd1, '0);
    chk("same_cycle_rd2", vif.rd2, '0);
`endif
    edge_step();
    idle();
    chk("next_cycle_rd1", vif.rd1, l4(32'h0, 32'h0, 32'h5, 32'h5));
    chk("next_cycle_drop", VW'(vif.drop), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
